// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: FSM encoding, key-length codes, Rcon limits, field polynomial
package aes_pkg;

    // Round-constant generator FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // key_len codes as issued by the key-schedule controller
    localparam logic [1:0] KEYLEN_128  = 2'b00;
    localparam logic [1:0] KEYLEN_192  = 2'b01;
    localparam logic [1:0] KEYLEN_256  = 2'b10;
    localparam logic [1:0] KEYLEN_RSVD = 2'b11;

    // Number of round constants consumed by each key expansion
    localparam int RCON_LIMIT_128 = 10;
    localparam int RCON_LIMIT_192 = 8;
    localparam int RCON_LIMIT_256 = 7;

    // GF(2^8) reduction constant (x^8 = x^4 + x^3 + x + 1) and first Rcon
    localparam logic [7:0] AES_POLY   = 8'h1B;
    localparam logic [7:0] RCON_FIRST = 8'h01;

    // Sequence length for a key_len code; the reserved code maps to zero
    function automatic logic [3:0] rcon_limit(input logic [1:0] key_len);
        logic [3:0] lim;
        case (key_len)
            KEYLEN_128: lim = 4'(RCON_LIMIT_128);
            KEYLEN_192: lim = 4'(RCON_LIMIT_192);
            KEYLEN_256: lim = 4'(RCON_LIMIT_256);
            default:    lim = 4'd0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/gf_xtime.sv
// rtl/gf_xtime.sv - combinational GF(2^8) multiply-by-x with configurable reduction constant
module gf_xtime #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Shift left; fold the overflowing bit back in with the reduction constant
    always_comb begin
        y = {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
    end

endmodule

// File: rtl/aes_rcon_gen.sv
// rtl/aes_rcon_gen.sv - sequential AES round-constant generator with valid/ready output; RCON_WRAP_EN selects continuous wrap instead of DONE
module aes_rcon_gen
    import aes_pkg::*;
#(
    parameter int         WORD_W  = 32,
    parameter logic [7:0] RC_POLY = AES_POLY,
    parameter int         IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] rcon_word,
    output logic [IDX_W-1:0]  idx,
    output logic              done,
    output logic              err
);

    logic [1:0]       state;
    logic [7:0]       rc;
    logic [7:0]       rc_next;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] limit;
    logic             valid_q;
    logic             done_q;
    logic             err_q;

    logic             idle_like;
    logic             accept;
    logic             last;
    logic             load;
    logic             reject;
    logic             advance;
    logic             finish;

    gf_xtime #(
        .POLY (RC_POLY)
    ) u_xtime (
        .a (rc),
        .y (rc_next)
    );

    // Decode handshake events; start is only honoured outside RUN
    always_comb begin
        idle_like = (state == ST_IDLE) || (state == ST_DONE);
        accept    = valid_q & out_ready;
        last      = (idx_q == limit);
        load      = idle_like & start & (key_len != KEYLEN_RSVD);
        reject    = idle_like & start & (key_len == KEYLEN_RSVD);
        advance   = (state == ST_RUN) & accept & ~last;
        finish    = (state == ST_RUN) & accept & last;
    end

    // Control state: FSM, output valid, done level/pulse and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= reject;
            if (load) begin
                state   <= ST_RUN;
                valid_q <= 1'b1;
                done_q  <= 1'b0;
            end else if (finish) begin
`ifdef RCON_WRAP_EN
                // Restart in place; done marks the wrap for a single cycle
                done_q  <= 1'b1;
`else
                state   <= ST_DONE;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
`endif
            end else begin
`ifdef RCON_WRAP_EN
                done_q <= 1'b0;
`endif
                if ((state != ST_IDLE) && (state != ST_RUN) && (state != ST_DONE)) begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            end
        end
    end

    // Datapath: round constant, 1-based index and per-key-size sequence length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc    <= RCON_FIRST;
            idx_q <= '0;
            limit <= '0;
        end else begin
            if (load) begin
                rc    <= RCON_FIRST;
                idx_q <= IDX_W'(1);
                limit <= IDX_W'(rcon_limit(key_len));
            end else if (advance) begin
                rc    <= rc_next;
                idx_q <= idx_q + IDX_W'(1);
            end else if (finish) begin
`ifdef RCON_WRAP_EN
                rc    <= RCON_FIRST;
                idx_q <= IDX_W'(1);
`else
                // Final word stays visible on rcon_word/idx after the sequence ends
                rc    <= rc;
                idx_q <= idx_q;
`endif
            end
        end
    end

    // The Rcon byte sits in the top byte of the word; lower bytes are zero
    generate
        if (WORD_W == 8) begin : g_byte_word
            assign rcon_word = rc;
        end else begin : g_wide_word
            assign rcon_word = {rc, {(WORD_W-8){1'b0}}};
        end
    endgenerate

    assign out_valid = valid_q;
    assign idx       = idx_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_aes_rcon_gen.sv
// tb/tb_aes_rcon_gen.sv - directed self-checking bench for aes_rcon_gen (define RCON_WRAP_EN to exercise wrap build)
module tb_aes_rcon_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  key_len;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] rcon_word;
    logic [3:0]  idx;
    logic        done;
    logic        err;

    int checks;
    int errors;

    logic [7:0] exp_rc [0:9];

    aes_rcon_gen #(
        .WORD_W  (32),
        .RC_POLY (8'h1B),
        .IDX_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_len   (key_len),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .rcon_word (rcon_word),
        .idx       (idx),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; key_len = 2'b00; out_ready = 1'b0;
        tick; tick;
        checks++;
        if (out_valid !== 1'b0 || idx !== 4'd0 || done !== 1'b0 || err !== 1'b0 || rcon_word !== 32'h0100_0000) begin
            errors++;
            $display("FAIL reset_state: valid=%b idx=%0d done=%b err=%b word=%h, want 0 0 0 0 01000000", out_valid, idx, done, err, rcon_word);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b done=%b, want 0 0", out_valid, done);
        end
    endtask

    task automatic test_aes128;
        key_len = 2'b00; out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || rcon_word !== {exp_rc[i], 24'h0} || idx !== 4'(i + 1) || done !== 1'b0) begin
                errors++;
                $display("FAIL aes128_word%0d: valid=%b word=%h idx=%0d done=%b, want 1 %h %0d 0", i, out_valid, rcon_word, idx, done, {exp_rc[i], 24'h0}, i + 1);
            end
            tick;
        end
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1 || idx !== 4'd10 || rcon_word !== 32'h3600_0000) begin
            errors++;
            $display("FAIL aes128_done: valid=%b done=%b idx=%0d word=%h, want 0 1 10 36000000", out_valid, done, idx, rcon_word);
        end
    endtask

    task automatic test_aes256_backpressure;
        key_len = 2'b10; out_ready = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL aes256_restart: done=%b valid=%b, want 0 1", done, out_valid);
        end
        for (int i = 0; i < 7; i++) begin
            out_ready = 1'b0;
            tick;
            checks++;
            if (out_valid !== 1'b1 || rcon_word !== {exp_rc[i], 24'h0} || idx !== 4'(i + 1)) begin
                errors++;
                $display("FAIL aes256_stall%0d: valid=%b word=%h idx=%0d, want 1 %h %0d", i, out_valid, rcon_word, idx, {exp_rc[i], 24'h0}, i + 1);
            end
            out_ready = 1'b1;
            tick;
        end
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1 || idx !== 4'd7 || rcon_word !== 32'h4000_0000) begin
            errors++;
            $display("FAIL aes256_done: valid=%b done=%b idx=%0d word=%h, want 0 1 7 40000000", out_valid, done, idx, rcon_word);
        end
    endtask

    task automatic test_reset_midrun;
        key_len = 2'b00; out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        checks++;
        if (rcon_word !== 32'h0800_0000 || idx !== 4'd4) begin
            errors++;
            $display("FAIL midrun_pre: word=%h idx=%0d, want 08000000 4", rcon_word, idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || idx !== 4'd0 || rcon_word !== 32'h0100_0000 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b idx=%0d word=%h done=%b, want 0 0 01000000 0", out_valid, idx, rcon_word, done);
        end
        tick;
        rst = 1'b0;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || idx !== 4'd1 || rcon_word !== 32'h0100_0000) begin
            errors++;
            $display("FAIL restart_after_reset: valid=%b idx=%0d word=%h, want 1 1 01000000", out_valid, idx, rcon_word);
        end
        tick;
        checks++;
        if (idx !== 4'd2 || rcon_word !== 32'h0200_0000) begin
            errors++;
            $display("FAIL second_after_reset: idx=%0d word=%h, want 2 02000000", idx, rcon_word);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_errors_and_aes192;
        key_len = 2'b11; out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err=%b valid=%b, want 1 0", err, out_valid);
        end
        tick;
        checks++;
        if (err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b valid=%b, want 0 0", err, out_valid);
        end
        key_len = 2'b01; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        key_len = 2'b00; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || idx !== 4'd3 || rcon_word !== 32'h0400_0000) begin
            errors++;
            $display("FAIL start_in_run: err=%b idx=%0d word=%h, want 0 3 04000000", err, idx, rcon_word);
        end
        for (int i = 2; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || rcon_word !== {exp_rc[i], 24'h0} || idx !== 4'(i + 1)) begin
                errors++;
                $display("FAIL aes192_word%0d: valid=%b word=%h idx=%0d, want 1 %h %0d", i, out_valid, rcon_word, idx, {exp_rc[i], 24'h0}, i + 1);
            end
            tick;
        end
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1 || idx !== 4'd8 || rcon_word !== 32'h8000_0000) begin
            errors++;
            $display("FAIL aes192_done: valid=%b done=%b idx=%0d word=%h, want 0 1 8 80000000", out_valid, done, idx, rcon_word);
        end
        key_len = 2'b11; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_in_done: err=%b done=%b valid=%b, want 1 1 0", err, done, out_valid);
        end
        key_len = 2'b00; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b1 || idx !== 4'd1 || rcon_word !== 32'h0100_0000) begin
            errors++;
            $display("FAIL restart_128: done=%b valid=%b idx=%0d word=%h, want 0 1 1 01000000", done, out_valid, idx, rcon_word);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || rcon_word !== {exp_rc[i], 24'h0} || idx !== 4'(i + 1)) begin
                errors++;
                $display("FAIL restart_word%0d: valid=%b word=%h idx=%0d, want 1 %h %0d", i, out_valid, rcon_word, idx, {exp_rc[i], 24'h0}, i + 1);
            end
            if (i == 9) begin
                key_len = 2'b10; start = 1'b1;
            end
            tick;
            start = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1 || idx !== 4'd10) begin
            errors++;
            $display("FAIL start_on_final: valid=%b done=%b idx=%0d, want 0 1 10", out_valid, done, idx);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL start_on_final_hold: valid=%b done=%b, want 0 1", out_valid, done);
        end
    endtask

    task automatic test_wrap;
        key_len = 2'b10; out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (out_valid !== 1'b1 || rcon_word !== {exp_rc[c % 7], 24'h0} || idx !== 4'((c % 7) + 1) ||
                done !== ((c > 0) && (c % 7 == 0)) || err !== 1'b0) begin
                errors++;
                $display("FAIL wrap_cycle%0d: valid=%b word=%h idx=%0d done=%b err=%b, want 1 %h %0d %b 0", c, out_valid, rcon_word, idx, done, err,
                         {exp_rc[c % 7], 24'h0}, (c % 7) + 1, (c > 0) && (c % 7 == 0));
            end
            if (c == 3) begin
                key_len = 2'b00; start = 1'b1;
            end else if (c == 10) begin
                key_len = 2'b11; start = 1'b1;
            end
            tick;
            start = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_rc[0] = 8'h01; exp_rc[1] = 8'h02; exp_rc[2] = 8'h04; exp_rc[3] = 8'h08; exp_rc[4] = 8'h10;
        exp_rc[5] = 8'h20; exp_rc[6] = 8'h40; exp_rc[7] = 8'h80; exp_rc[8] = 8'h1B; exp_rc[9] = 8'h36;
        test_reset;
`ifdef RCON_WRAP_EN
        test_wrap;
`else
        test_aes128;
        test_aes256_backpressure;
        test_reset_midrun;
        test_errors_and_aes192;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
